// File: rtl/branch_redirect_ctrl.sv
// Branch prediction (2-bit BHT) and EX-stage redirect/flush sequencing for the RV32I pipeline.
// Optional performance counters are enabled by defining BRANCH_PERF_CNT_EN.
module branch_redirect_ctrl #(
    parameter int         IDX_W     = 6,
    parameter logic [1:0] CNT_INIT  = 2'b01,
    parameter int         FLUSH_CYC = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_pc,
    output logic        pred_taken,
    input  logic        ex_valid,
    input  logic        ex_is_branch,
    input  logic        ex_is_jump,
    input  logic        ex_pred_taken,
    input  logic        ex_jump_flag,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_target,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        flush_if_id,
    output logic        flush_id_ex,
    output logic [31:0] branch_cnt,
    output logic [31:0] mispred_cnt
);

    localparam int         ENTRIES    = 1 << IDX_W;
    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYC - 1);

    typedef enum logic {S_IDLE, S_FLUSH} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_flush_cnt;
    logic [2:0]  w_flush_cnt_nxt;
    logic [1:0]  r_bht [ENTRIES];
    logic        r_redirect_valid;
    logic [31:0] r_redirect_pc;

    logic [IDX_W-1:0] w_rd_idx;
    logic [IDX_W-1:0] w_wr_idx;
    logic             w_resolve;
    logic             w_redirect;
    logic             w_bht_we;
    logic [31:0]      w_redirect_pc;
    logic             w_unused_if_pc;

    function automatic logic [1:0] sat_step(input logic [1:0] cnt, input logic up);
        logic [1:0] res;
        if (up) begin
            res = (cnt == 2'b11) ? cnt : cnt + 2'b01;
        end else begin
            res = (cnt == 2'b00) ? cnt : cnt - 2'b01;
        end
        return res;
    endfunction

    assign w_rd_idx       = if_pc[IDX_W+1:2];
    assign w_wr_idx       = ex_pc[IDX_W+1:2];
    assign w_unused_if_pc = ^{if_pc[31:IDX_W+2], if_pc[1:0]};

    // EX inputs only count while IDLE; a jump takes precedence over the branch flag.
    assign w_resolve     = (r_state == S_IDLE) && ex_valid && (ex_is_jump || ex_is_branch);
    assign w_redirect    = w_resolve && (ex_is_jump || (ex_is_branch && (ex_pred_taken != ex_jump_flag)));
    assign w_bht_we      = w_resolve && ex_is_branch && !ex_is_jump;
    assign w_redirect_pc = (ex_is_jump || ex_jump_flag) ? ex_target : ex_pc + 32'd4;

    // Read sees the stored value, so a same-cycle write to the same entry shows up next cycle.
    assign pred_taken = r_bht[w_rd_idx][1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_bht[i] <= CNT_INIT;
            end
        end else if (w_bht_we) begin
            r_bht[w_wr_idx] <= sat_step(r_bht[w_wr_idx], ex_jump_flag);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_flush_cnt <= 3'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_flush_cnt <= w_flush_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_flush_cnt_nxt = r_flush_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_redirect) begin
                    w_state_nxt     = S_FLUSH;
                    w_flush_cnt_nxt = FLUSH_LOAD;
                end
            end
            S_FLUSH: begin
                if (r_flush_cnt == 3'd0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_flush_cnt_nxt = r_flush_cnt - 3'd1;
                end
            end
            default: begin
                w_state_nxt     = S_IDLE;
                w_flush_cnt_nxt = 3'd0;
            end
        endcase
    end

    always_comb begin
        flush_if_id    = (r_state == S_FLUSH);
        flush_id_ex    = (r_state == S_FLUSH);
        redirect_valid = r_redirect_valid;
        redirect_pc    = r_redirect_pc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= 32'd0;
        end else begin
            r_redirect_valid <= w_redirect;
            if (w_redirect) begin
                r_redirect_pc <= w_redirect_pc;
            end
        end
    end

`ifdef BRANCH_PERF_CNT_EN
    logic [31:0] r_branch_cnt;
    logic [31:0] r_mispred_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_branch_cnt  <= 32'd0;
            r_mispred_cnt <= 32'd0;
        end else begin
            if (w_bht_we && (r_branch_cnt != 32'hFFFF_FFFF)) begin
                r_branch_cnt <= r_branch_cnt + 32'd1;
            end
            if (w_redirect && (r_mispred_cnt != 32'hFFFF_FFFF)) begin
                r_mispred_cnt <= r_mispred_cnt + 32'd1;
            end
        end
    end

    assign branch_cnt  = r_branch_cnt;
    assign mispred_cnt = r_mispred_cnt;
`else
    assign branch_cnt  = 32'd0;
    assign mispred_cnt = 32'd0;
`endif

endmodule

// File: doc/branch_redirect_ctrl.md
Name: branch_redirect_ctrl

Overview:
- Sequences control flow for the RV32I pipeline: a 2-bit saturating branch history table (BHT) predicts conditional branches at fetch.
- Resolves each branch/jump in EX against the branch judge's jump_flag.
- On a mispredict or jump: issues a registered PC redirect and a fixed-length pipeline flush.
- Sits between the branch judge (EX), the PC register (IF) and the IF/ID, ID/EX pipeline registers.

Parameters:
- IDX_W, 6, BHT index width; 2^IDX_W entries indexed by pc[IDX_W+1:2].
- CNT_INIT, 2'b01, reset value of every BHT counter (weakly not-taken).
- FLUSH_CYC, 2, cycles flush_if_id/flush_id_ex stay asserted per redirect; legal range 1..7.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- if_pc  in  32  fetch PC, BHT lookup address
- pred_taken  out  1  prediction for if_pc; combinational read of BHT[if_pc[IDX_W+1:2]] bit 1
- ex_valid  in  1  EX holds a real instruction
- ex_is_branch  in  1  EX instruction is beq/bne/blt/bge/bltu/bgeu
- ex_is_jump  in  1  EX instruction is jal/jalr
- ex_pred_taken  in  1  pred_taken carried with the instruction into EX
- ex_jump_flag  in  1  branch judge outcome
- ex_pc  in  32  PC of EX instruction
- ex_target  in  32  computed branch/jump target
- redirect_valid  out  1  PC must load redirect_pc this cycle
- redirect_pc  out  32  new fetch PC
- flush_if_id  out  1  bubble IF/ID
- flush_id_ex  out  1  bubble ID/EX
- branch_cnt  out  32  resolved branch count (optional feature)
- mispred_cnt  out  32  redirect count (optional feature)

Behaviour:
- Clocking: single clock, clk; reset asynchronous, active-high, port rst.
- Reset values: all BHT entries = CNT_INIT; state = IDLE; redirect_valid=0; redirect_pc=0; flush_if_id=0; flush_id_ex=0; counters=0.
- States: IDLE, FLUSH.
- Resolve event (IDLE only): ex_valid & (ex_is_jump | ex_is_branch).
  - Redirect needed when ex_is_jump, or when ex_is_branch & (ex_pred_taken != ex_jump_flag).
  - ex_is_jump has priority if both ex_is_jump and ex_is_branch are set.
- Redirect timing: resolve at edge t; registered outputs at t+1.
  - redirect_valid=1 for exactly one cycle.
  - redirect_pc = ex_target if ex_jump_flag (or jump), else ex_pc+4 (32-bit wrap; 0xFFFFFFFC+4 = 0).
  - flush_if_id and flush_id_ex = 1 for FLUSH_CYC cycles starting t+1.
  - state goes to FLUSH; the down-counter is loaded with FLUSH_CYC-1.
- FLUSH state:
  - All EX inputs are ignored: no BHT update, no new redirect, no counting.
  - Returns to IDLE when the counter reaches 0; flushes deassert in the same cycle.
- Correct prediction: no redirect, no flush, stays IDLE.
- BHT update: on every IDLE resolve event with ex_is_branch, entry at ex_pc[IDX_W+1:2] is written at the clock edge.
  - taken: +1, saturating at 3.
  - not taken: -1, saturating at 0.
  - Jumps never update the BHT.
- Read/write collision: pred_taken reads the pre-update value when if_pc and ex_pc index the same entry in the same cycle.
- Prediction: pred_taken = counter[1].
- Reset mid-FLUSH: immediately returns to IDLE with all outputs at reset values; BHT reinitialised.
- ex_valid=0: all other EX inputs are don't-care.

Optional Feature:
- Macro: BRANCH_PERF_CNT_EN.
- Defined:
  - branch_cnt increments on each IDLE resolve event with ex_is_branch.
  - mispred_cnt increments on each redirect.
  - Both saturate at 0xFFFFFFFF.
- Undefined: both ports stay present, tied to 0; no counter flops are synthesised.

Test Plan:
- Reset → pred_taken=0 for any if_pc; all outputs 0. Six not-taken branches at ex_pc=0x40 with ex_pred_taken=0 → no redirect; entry stays at 0.
- Branch ex_pc=0x100, ex_pred_taken=0, ex_jump_flag=1, ex_target=0x80 → next cycle redirect_valid=1, redirect_pc=0x80; flushes high exactly 2 cycles; then if_pc=0x100 gives pred_taken=1 (counter 2).
- Branch ex_pc=0x200, ex_pred_taken=1, ex_jump_flag=0 → redirect_pc=0x204, flush 2 cycles. A second branch presented during FLUSH → ignored: no redirect, BHT unchanged.
- jal at ex_pc=0x10, target 0x400 → redirect_pc=0x400; BHT entry 4 unchanged. ex_pc=0xFFFFFFFC not-taken mispredict → redirect_pc=0x0.
- Taken branch ex_pc=0x8 while if_pc=0x108 (same index, IDX_W=6) → pred_taken shows old value that cycle, new value next cycle; rst asserted mid-FLUSH → flushes drop asynchronously.
- With BRANCH_PERF_CNT_EN: 3 branches (1 mispredicted) plus 1 jal → branch_cnt=3, mispred_cnt=2. Without the macro → both read 0.
